branch_flag_unit: RTL
=====================

# branch_flag_unit

Execute-stage flag register and branch resolver for the CPU pipeline. It captures N/Z from compare results and drives `flagN`/`flagZ` back into the control decoder. It evaluates beq/bgt/blt/b against the held flags and issues a registered PC redirect plus a multi-cycle flush of wrong-path instructions. It sits between the ALU output of the EX stage and the fetch PC mux.

## Interface
- `PC_W`, 32, program-counter and branch-offset width
- `DATA_W`, 32, ALU result width
- `FLUSH_CYCLES`, 2, cycles of squash after a taken branch; legal range 1..15
- `CNT_W`, 16, width of taken-branch counter

- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  EX stage holds a real instruction this cycle
- `ex_opcode`  in  4  opcode of EX instruction (same encoding as the control decoder)
- `ex_pc`  in  PC_W  address of EX instruction
- `ex_imm`  in  PC_W  signed branch offset, already sign-extended
- `alu_result`  in  DATA_W  ALU output for EX instruction
- `flagN`  out  1  registered negative flag
- `flagZ`  out  1  registered zero flag
- `pc_sel`  out  1  one-cycle pulse: fetch must load `branch_target`
- `branch_target`  out  PC_W  redirect address, valid while `pc_sel`=1
- `flush`  out  1  squash signal to IF/ID/EX pipeline registers
- `taken_cnt`  out  CNT_W  saturating count of taken branches

## Operation
- Opcodes used: cmp=1011, beq=0100, bgt=0101, blt=0110, b=0111; all others are ignored.
- Accepted instruction: `ex_valid`=1 and state is not FLUSH.
- Flag update:
  - Only an accepted cmp updates the flags.
  - `flagN` <= `alu_result[DATA_W-1]`.
  - `flagZ` <= (`alu_result` == 0).
  - The flags hold otherwise, including across branches and flushes.
- Branch conditions, evaluated on the currently registered flags (not the same-cycle cmp):
  - beq: taken if Z=1.
  - bgt: taken if N=0 and Z=0.
  - blt: taken if N=1.
  - b: always taken.
- Target: `ex_pc + ex_imm`, modulo 2^PC_W (wrap-around, no overflow detection).
- States:
  - IDLE → FLUSH on an accepted taken branch. The counter loads FLUSH_CYCLES, `pc_sel` pulses, and `branch_target` is registered.
  - FLUSH: `flush`=1. The counter decrements each cycle. Return to IDLE when the count reaches 1 at a clock edge.
  - A not-taken branch stays in IDLE with no outputs changing.
- `taken_cnt` increments on each accepted taken branch and saturates at all-ones.

## Timing
- Reset (async assert, sync-clean deassert): `flagN`=0, `flagZ`=0, `pc_sel`=0, `branch_target`=0, `flush`=0, `taken_cnt`=0, state IDLE, counter 0.
- Asserting `rst_n` mid-FLUSH aborts immediately; the first cycle after release is IDLE.
- A cmp sampled at edge t gives flags visible from cycle t+1. A branch in EX during cycle t+1 uses them, so back-to-back cmp→branch needs no stall.
- A taken branch sampled at edge t gives:
  - `pc_sel`=1 and `branch_target` valid in cycle t+1 only;
  - `flush`=1 for cycles t+1 … t+FLUSH_CYCLES;
  - `flush` low again in cycle t+FLUSH_CYCLES+1.
- During `flush`=1 every EX input is ignored: cmp does not touch the flags, branches are not taken, and the counter does not move.
- `branch_target` holds its last value when `pc_sel`=0.
- Latency of branch decision to redirect: 1 cycle. There is no back-pressure; fetch must accept `pc_sel` unconditionally.

## Test plan
- **Reset:** assert `rst_n`=0 mid-FLUSH (FLUSH_CYCLES=2, one cycle in) → all outputs 0 asynchronously; after release, next cmp with result 0 → `flagZ`=1 one cycle later.
- **Branch conditions:**
  - cmp `alu_result`=0xFFFFFFF0, then blt with `ex_pc`=0x100, `ex_imm`=0x20 next cycle → N=1, Z=0; `pc_sel` pulse with `branch_target`=0x120; `flush` high exactly 2 cycles; `taken_cnt`=1.
  - cmp result 5, then bgt → taken.
  - cmp result 5, then beq → not taken, `pc_sel`/`flush` stay 0.
- **Wrong-path squash:** taken b followed by cmp result 0 and blt during the flush window → flags unchanged, no second `pc_sel`, `taken_cnt` +1 only.
- **Wrap-around:** b with `ex_pc`=0xFFFFFFF8, `ex_imm`=0x10 → `branch_target`=0x00000008; `ex_imm`=0xFFFFFFFC with `ex_pc`=0x4 → 0x0.
- **Counter saturation:** CNT_W=4, 17 taken branches separated by flush windows → `taken_cnt` stops at 0xF.
- **Ignored inputs:** `ex_valid`=0 with cmp/beq opcodes, and opcodes 1101/1111 with `ex_valid`=1 → no flag, `pc_sel`, or `flush` activity.

Source files
------------

// File: rtl/branch_flag_unit.sv
// Execute-stage N/Z flag register and branch resolver.
// Issues a one-cycle registered PC redirect and a multi-cycle wrong-path flush.
module branch_flag_unit #(
    parameter int unsigned PC_W         = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [PC_W-1:0]   ex_imm,
    input  logic [DATA_W-1:0] alu_result,
    output logic              flagN,
    output logic              flagZ,
    output logic              pc_sel,
    output logic [PC_W-1:0]   branch_target,
    output logic              flush,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam int unsigned FC_W = 4;

    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_BEQ = 4'b0100;
    localparam logic [3:0] OP_BGT = 4'b0101;
    localparam logic [3:0] OP_BLT = 4'b0110;
    localparam logic [3:0] OP_B   = 4'b0111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              flag_n_q, flag_z_q;
    logic              pc_sel_q, flush_q;
    logic [PC_W-1:0]   target_q;
    logic [CNT_W-1:0]  taken_cnt_q;

    logic              cmp_c;
    logic              taken_c;
    logic [PC_W-1:0]   target_c;

    // Next-state and branch decision; branches read only the registered flags
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        cmp_c    = 1'b0;
        taken_c  = 1'b0;
        target_c = ex_pc + ex_imm;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    case (ex_opcode)
                        OP_CMP:  cmp_c   = 1'b1;
                        OP_BEQ:  taken_c = flag_z_q;
                        OP_BGT:  taken_c = !flag_n_q && !flag_z_q;
                        OP_BLT:  taken_c = flag_n_q;
                        OP_B:    taken_c = 1'b1;
                        default: ;
                    endcase
                end
                if (taken_c) begin
                    state_d = FLUSH;
                    fcnt_d  = FC_W'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (fcnt_q == FC_W'(1)) begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fcnt_q      <= '0;
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            pc_sel_q    <= 1'b0;
            flush_q     <= 1'b0;
            target_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            pc_sel_q <= taken_c;
            flush_q  <= (state_d == FLUSH);
            if (taken_c) begin
                target_q <= target_c;
            end
            if (cmp_c) begin
                flag_n_q <= alu_result[DATA_W-1];
                flag_z_q <= (alu_result == '0);
            end
            if (taken_c && (taken_cnt_q != '1)) begin
                taken_cnt_q <= taken_cnt_q + CNT_W'(1);
            end
        end
    end

    assign flagN         = flag_n_q;
    assign flagZ         = flag_z_q;
    assign pc_sel        = pc_sel_q;
    assign flush         = flush_q;
    assign branch_target = target_q;
    assign taken_cnt     = taken_cnt_q;

endmodule
